// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, and buffers fetched {pc, instr}
// pairs in a small in-order queue that is drained by decode through valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misaligned
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      buf_pc_q    [BUF_DEPTH];
  logic [31:0]      buf_instr_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misaligned_q, misaligned_d;
  logic             full, pop, push;

  assign full      = (count_q == CNT_W'(BUF_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full buffer can still accept when the head leaves in the same cycle.
  assign push      = ~redirect_valid & (~full | pop);

  assign imem_pc      = fetch_pc_q;
  assign out_pc       = buf_pc_q[rd_ptr_q];
  assign out_instr    = buf_instr_q[rd_ptr_q];
  assign out_pc_plus4 = buf_pc_q[rd_ptr_q] + 32'd4;
  assign misaligned   = misaligned_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    misaligned_d = misaligned_q;
    if (redirect_valid) begin
      fetch_pc_d   = {redirect_target[31:2], 2'b00};
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      misaligned_d = misaligned_q | (|redirect_target[1:0]);
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Storage is not reset; entries are only observable once counted in.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_pc_q[wr_ptr_q]    <= fetch_pc_q;
      buf_instr_q[wr_ptr_q] <= imem_instr;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the combinational instruction memory and downstream-facing to decode. Owns the program counter, drives the fetch address to instruction memory, and captures the returned word together with its PC. Captured entries go into a small in-order buffer, which presents them to decode through a valid/ready handshake. Branch/jump redirects from execute flush the buffer and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUF_DEPTH, 2, fetch buffer entries; power of two, minimum 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
imem_pc  output  32  fetch address to instruction memory; equals fetch_pc combinationally.
imem_instr  input  32  instruction word returned combinationally for imem_pc.
redirect_valid  input  1  taken branch/jump this cycle.
redirect_target  input  32  new PC when redirect_valid=1.
out_valid  output  1  buffer head holds a valid instruction.
out_ready  input  1  decode accepts the head this cycle.
out_instr  output  32  head instruction word.
out_pc  output  32  PC of head instruction.
out_pc_plus4  output  32  out_pc + 4, mod 2^32.
misaligned  output  1  sticky flag; a redirect target had [1:0] != 0.

Behaviour:
- State: fetch_pc (32b), circular buffer of {pc, instr} with read/write pointers and a count (0..BUF_DEPTH), and misaligned.
- Reset (sync, priority over everything): fetch_pc=RESET_PC, count=0, pointers=0, misaligned=0. Outputs in reset cycle and after: out_valid=0. out_instr, out_pc and out_pc_plus4 are don't-care while out_valid=0.
- pop = out_valid & out_ready. push = ~redirect_valid & (count < BUF_DEPTH | pop).
- On push: write {fetch_pc, imem_instr} at the write pointer, advance the pointer, and set fetch_pc <= fetch_pc + 4 (wraps 0xFFFF_FFFC -> 0x0000_0000).
- If no push and no redirect: fetch_pc holds.
- On pop: advance the read pointer. Count changes by push - pop; a simultaneous push and pop while full is legal and count stays BUF_DEPTH.
- Redirect (redirect_valid=1, no reset):
  - Flush the buffer: count=0, pointers=0.
  - No push occurs that cycle.
  - A concurrent pop is irrelevant (entry discarded).
  - fetch_pc <= {redirect_target[31:2], 2'b00}.
  - If redirect_target[1:0] != 0, set misaligned=1; it is cleared only by reset.
- Latency: an instruction fetched in cycle N appears at the head with out_valid=1 in cycle N+1 at the earliest. After reset deasserts, the first out_valid is one cycle later. After a redirect in cycle N, the target instruction is valid in cycle N+2.
- Throughput: with out_ready held at 1, one instruction per cycle, with no bubbles except after a redirect.
- Head outputs are driven from registered buffer contents. imem_pc is the only combinational output path (from fetch_pc).
- Handshake: while out_valid=1 and out_ready=0, the head outputs stay stable. Only a redirect or reset may drop out_valid without a pop.

Test Plan:
1. Reset, then out_ready=1, with imem modelled as 0x0:FFC4A303, 0x4:0064A423, 0x8:0062E233 -> out_valid rises one cycle after reset release. Heads are (pc 0x0, FFC4A303), (0x4, 0064A423), (0x8, 0062E233) on consecutive cycles. out_pc_plus4 = 0x4/0x8/0xC.
2. Backpressure: out_ready=0 for 5 cycles after reset -> count saturates at 2 and fetch_pc stalls at 0x8 (imem_pc=0x8). Head stays (0x0, FFC4A303). Releasing out_ready delivers 0x0, 0x4, 0x8 in order with no loss or duplication.
3. Redirect while the buffer is full with redirect_target=0x0, at the moment imem_pc=0x14 (word FE4206E3 present) -> next cycle out_valid=0 and imem_pc=0x0. The cycle after, the head is (0x0, FFC4A303). The 0x14 word is never emitted.
4. Misaligned redirect to 0x0000_000E -> fetch continues at 0xC and misaligned=1. misaligned stays 1 across later aligned redirects and clears only on reset.
5. Wrap-around: RESET_PC=0xFFFF_FFF8, out_ready=1 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. out_pc_plus4 for 0xFFFF_FFFC is 0x0000_0000.
6. Reset asserted mid-stream, with 2 entries buffered and a simultaneous redirect -> next cycle out_valid=0, imem_pc=RESET_PC, misaligned=0; the redirect is ignored.
